// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_NOT  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_ASHR = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int FLAG_C = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_L = 0;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ASHR);
  endfunction

endpackage

// File: rtl/alu_logic_arith.sv
// Single-cycle logic/add/sub results with carry, overflow and less-than; purely combinational.
// zn_src is the value Z/N are taken from (the difference for CMP, otherwise the result).
module alu_logic_arith
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] zn_src,
  output logic             c_out,
  output logic             v_out,
  output logic             l_out,
  output logic             err_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           add_v;
  logic           sub_v;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    res     = '0;
    c_out   = 1'b0;
    v_out   = 1'b0;
    l_out   = 1'b0;
    err_out = 1'b0;
    case (op)
      OP_NOT: res = ~a;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        c_out = sum[WIDTH];
        v_out = add_v;
      end
      OP_SUB, OP_CMP: begin
        // diff[WIDTH] is the borrow, which is exactly unsigned A<B
        res   = (op == OP_CMP) ? a : diff[WIDTH-1:0];
        c_out = diff[WIDTH];
        v_out = sub_v;
        l_out = diff[WIDTH];
      end
      OP_SHR, OP_SHL, OP_ASHR: res = '0;
      default: err_out = 1'b1;
    endcase
    zn_src = (op == OP_CMP) ? diff[WIDTH-1:0] : res;
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: logic/arith latency 1, shifts latency amt+1 via a 1-bit/cycle shifter.
// Result held in DONE until out_ready; in_ready only in IDLE, so no overlap between operations.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       instruction,
  input  logic [WIDTH-1:0] data_in_A,
  input  logic [WIDTH-1:0] data_in_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [4:0]       flags,
  output logic             op_err
);

  localparam logic [SHAMT_W-1:0] CNT_MAX = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [4:0]         flags_q, flags_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   la_res, la_zn;
  logic               la_c, la_v, la_l, la_err;
  logic [SHAMT_W-1:0] amt_raw, amt;
  logic [WIDTH-1:0]   sh_next;
  logic               sh_bit;

  alu_logic_arith #(.WIDTH(WIDTH)) u_logic_arith (
    .op      (instruction),
    .a       (data_in_A),
    .b       (data_in_B),
    .res     (la_res),
    .zn_src  (la_zn),
    .c_out   (la_c),
    .v_out   (la_v),
    .l_out   (la_l),
    .err_out (la_err)
  );

  // Amounts beyond WIDTH behave exactly like WIDTH, so the counter saturates there
  assign amt_raw = data_in_B[SHAMT_W-1:0];
  assign amt     = (amt_raw > CNT_MAX) ? CNT_MAX : amt_raw;

  always_comb begin
    case (op_q)
      OP_SHL: begin
        sh_next = {data_q[WIDTH-2:0], 1'b0};
        sh_bit  = data_q[WIDTH-1];
      end
      OP_ASHR: begin
        sh_next = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        sh_bit  = data_q[0];
      end
      default: begin
        sh_next = {1'b0, data_q[WIDTH-1:1]};
        sh_bit  = data_q[0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = instruction;
          flags_d = '0;
          if (is_shift(instruction)) begin
            data_d          = data_in_A;
            cnt_d           = amt;
            err_d           = 1'b0;
            flags_d[FLAG_Z] = (data_in_A == '0);
            flags_d[FLAG_N] = data_in_A[WIDTH-1];
            state_d         = (amt == '0) ? S_DONE : S_SHIFT;
          end else begin
            data_d  = la_res;
            cnt_d   = '0;
            err_d   = la_err;
            state_d = S_DONE;
            if (!la_err) begin
              flags_d[FLAG_C] = la_c;
              flags_d[FLAG_Z] = (la_zn == '0);
              flags_d[FLAG_N] = la_zn[WIDTH-1];
              flags_d[FLAG_V] = la_v;
              flags_d[FLAG_L] = la_l;
            end
          end
        end
      end
      S_SHIFT: begin
        data_d          = sh_next;
        cnt_d           = cnt_q - CNT_ONE;
        flags_d         = '0;
        flags_d[FLAG_C] = sh_bit;
        flags_d[FLAG_Z] = (sh_next == '0);
        flags_d[FLAG_N] = sh_next[WIDTH-1];
        if (cnt_q == CNT_ONE) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign data_out  = data_q;
  assign flags     = flags_q;
  assign op_err    = err_q;

endmodule
